pc_gen_unit: RTL and testbench

Parametrised next-generation program counter generator for the pipelined core. It adds the following over the single-cycle PC unit:
- configurable width, reset vector and alignment;
- a fetch valid/ready handshake and a stall input;
- trap entry and mret with an internal exception-PC register;
- misaligned-target detection;
- a post-redirect flush bubble.

It sits between the execute-stage control-transfer logic and instruction memory.

---
 rtl/pc_gen_unit.sv | 154 +++++++++++++++
 tb/tb_pc_gen_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - pipelined program counter generator with fetch handshake, traps and flush bubble
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jalr_flag,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] jump_base,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] epc
);

  // BOOT holds fetch off for the first cycle out of reset; FLUSH is the
  // single bubble inserted after every control-flow redirect.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Bit 1 of a target only matters when every instruction is 32-bit aligned.
  localparam bit CHECK_BIT1 = (IALIGN == 32);

  state_t          state_q;
  state_t          state_d;
  logic            fetch_valid_d;

  logic            adv;
  logic            taken;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic            target_mis;

  logic            redir_any;
  logic            redir_mis;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] epc_d;

  // Sequential fetch only moves on when imem takes the address and no hazard holds it.
  assign adv   = (state_q == ST_RUN) & fetch_ready & ~stall;
  assign taken = ex_valid & (jump | (branch & zero));

  // Control-transfer target; JALR drops bit 0 so it can never be odd.
  always_comb begin
    target_sum = '0;
    target     = '0;
    if (jalr_flag) begin
      target_sum = jump_base + offset;
      target     = {target_sum[XLEN-1:1], 1'b0};
    end else begin
      target_sum = ex_pc + offset;
      target     = target_sum;
    end
  end

  // Alignment check on the target that would be fetched.
  always_comb begin
    target_mis = (CHECK_BIT1 & target[1]) | (~jalr_flag & target[0]);
  end

  // Redirect arbitration: trap, then mret, then faulting transfer, then good
  // transfer; only when none of them fires does the sequential step apply.
  always_comb begin
    pc_d      = pc;
    epc_d     = epc;
    redir_any = 1'b0;
    redir_mis = 1'b0;
    if (trap) begin
      pc_d      = trap_vec;
      epc_d     = ex_pc;
      redir_any = 1'b1;
    end else if (mret) begin
      pc_d      = epc;
      redir_any = 1'b1;
    end else if (taken && target_mis) begin
      pc_d      = trap_vec;
      epc_d     = ex_pc;
      redir_any = 1'b1;
      redir_mis = 1'b1;
    end else if (taken) begin
      pc_d      = target;
      redir_any = 1'b1;
    end else if (adv) begin
      pc_d      = pc + XLEN'(4);
    end
  end

  // State register; fetch_valid is registered alongside so it has no input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      fetch_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_valid <= fetch_valid_d;
    end
  end

  // Next-state logic: any redirect forces exactly one bubble cycle.
  always_comb begin
    state_d = state_q;
    if (redir_any) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // Output decode of the upcoming state, captured by the state register.
  always_comb begin
    fetch_valid_d = 1'b0;
    case (state_d)
      ST_RUN:  fetch_valid_d = 1'b1;
      default: fetch_valid_d = 1'b0;
    endcase
  end

  // PC, exception PC and the one-cycle redirect/misalign pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      epc      <= '0;
      redirect <= 1'b0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_d;
      epc      <= epc_d;
      redirect <= redir_any;
      misalign <= redir_mis;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb/tb_pc_gen_unit.sv - scoreboard bench for pc_gen_unit
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst, stall, fetch_ready;
  logic        ex_valid, branch, zero, jump, jalr_flag, trap, mret;
  logic [31:0] ex_pc, offset, jump_base, trap_vec;

  logic        fetch_valid, redirect, misalign;
  logic [31:0] pc, epc;
  logic        fetch_valid16, redirect16, misalign16;
  logic [31:0] pc16, epc16;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        fv;
    logic        red;
    logic        mis;
    logic [31:0] epc;
    logic        chk16;
    logic [31:0] pc16;
    logic        mis16;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          step_id = 0;
  logic        nxt_chk16 = 1'b0;
  logic [31:0] nxt_pc16  = '0;
  logic        nxt_mis16 = 1'b0;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .IALIGN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc(pc), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .branch(branch), .zero(zero), .jump(jump), .jalr_flag(jalr_flag),
    .offset(offset), .jump_base(jump_base), .trap(trap), .trap_vec(trap_vec),
    .mret(mret), .redirect(redirect), .misalign(misalign), .epc(epc)
  );

  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid16), .pc(pc16), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .branch(branch), .zero(zero), .jump(jump), .jalr_flag(jalr_flag),
    .offset(offset), .jump_base(jump_base), .trap(trap), .trap_vec(trap_vec),
    .mret(mret), .redirect(redirect16), .misalign(misalign16), .epc(epc16)
  );

  task automatic check32(input int id, input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s: got %h want %h", id, name, got, want);
    end
  endtask

  // Monitor: the DUT presents a new registered output every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check32(e.id, "pc",          pc,                  e.pc);
      check32(e.id, "fetch_valid", {31'd0, fetch_valid}, {31'd0, e.fv});
      check32(e.id, "redirect",    {31'd0, redirect},    {31'd0, e.red});
      check32(e.id, "misalign",    {31'd0, misalign},    {31'd0, e.mis});
      check32(e.id, "epc",         epc,                 e.epc);
      if (e.chk16) begin
        check32(e.id, "pc_ialign16",       pc16,                {31'd0, 1'b0} | e.pc16);
        check32(e.id, "misalign_ialign16", {31'd0, misalign16}, {31'd0, e.mis16});
      end
    end
  end

  // Advance one clock and queue the outputs expected right after that edge.
  task automatic tick(input logic [31:0] p, input logic f, input logic r, input logic m, input logic [31:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    step_id++;
    x.id = step_id; x.pc = p; x.fv = f; x.red = r; x.mis = m; x.epc = e;
    x.chk16 = nxt_chk16; x.pc16 = nxt_pc16; x.mis16 = nxt_mis16;
    sb_q.push_back(x);
    nxt_chk16 = 1'b0;
  endtask

  task automatic clr();
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    ex_valid = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jalr_flag = 1'b0;
    trap = 1'b0; mret = 1'b0;
    ex_pc = '0; offset = '0; jump_base = '0; trap_vec = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1; fetch_ready = 1'b0;
    tick(32'h1000, 0, 0, 0, 32'h0);
    tick(32'h1000, 0, 0, 0, 32'h0);
    rst = 1'b0; fetch_ready = 1'b1;
    tick(32'h1000, 1, 0, 0, 32'h0);
    tick(32'h1004, 1, 0, 0, 32'h0);
    tick(32'h1008, 1, 0, 0, 32'h0);

    stall = 1'b1;
    repeat (3) tick(32'h1008, 1, 0, 0, 32'h0);
    stall = 1'b0; fetch_ready = 1'b0;
    repeat (2) tick(32'h1008, 1, 0, 0, 32'h0);
    fetch_ready = 1'b1;

    ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h0; offset = 32'hFFFF_FFFC;
    tick(32'hFFFF_FFFC, 0, 1, 0, 32'h0);
    clr();
    tick(32'hFFFF_FFFC, 1, 0, 0, 32'h0);
    tick(32'h0000_0000, 1, 0, 0, 32'h0);
    tick(32'h0000_0004, 1, 0, 0, 32'h0);

    ex_valid = 1'b1; branch = 1'b1; zero = 1'b1; ex_pc = 32'h1004; offset = 32'h10;
    tick(32'h1014, 0, 1, 0, 32'h0);
    clr();
    tick(32'h1014, 1, 0, 0, 32'h0);
    tick(32'h1018, 1, 0, 0, 32'h0);
    ex_valid = 1'b1; branch = 1'b1; zero = 1'b0; ex_pc = 32'h1004; offset = 32'h10;
    tick(32'h101C, 1, 0, 0, 32'h0);
    clr();

    ex_valid = 1'b1; jump = 1'b1; jalr_flag = 1'b1; jump_base = 32'h2003; offset = 32'h4;
    trap_vec = 32'h80; ex_pc = 32'h1010;
    nxt_chk16 = 1'b1; nxt_pc16 = 32'h2006; nxt_mis16 = 1'b0;
    tick(32'h80, 0, 1, 1, 32'h1010);
    clr();
    tick(32'h80, 1, 0, 0, 32'h1010);
    tick(32'h84, 1, 0, 0, 32'h1010);

    trap = 1'b1; trap_vec = 32'h80; ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h1020; offset = 32'h40;
    tick(32'h80, 0, 1, 0, 32'h1020);
    clr();
    tick(32'h80, 1, 0, 0, 32'h1020);
    tick(32'h84, 1, 0, 0, 32'h1020);
    mret = 1'b1;
    tick(32'h1020, 0, 1, 0, 32'h1020);
    clr();
    tick(32'h1020, 1, 0, 0, 32'h1020);
    tick(32'h1024, 1, 0, 0, 32'h1020);

    ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h1024; offset = 32'h100; stall = 1'b1; fetch_ready = 1'b0;
    tick(32'h1124, 0, 1, 0, 32'h1020);
    ex_pc = 32'h1124; offset = 32'h20; stall = 1'b0; fetch_ready = 1'b1;
    tick(32'h1144, 0, 1, 0, 32'h1020);
    ex_pc = 32'h1144; offset = 32'h2; trap_vec = 32'h200;
    tick(32'h200, 0, 1, 1, 32'h1144);
    clr();
    rst = 1'b1; trap = 1'b1; trap_vec = 32'h80;
    tick(32'h1000, 0, 0, 0, 32'h0);
    clr();
    tick(32'h1000, 1, 0, 0, 32'h0);
    tick(32'h1004, 1, 0, 0, 32'h0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
